// File: rtl/z80bd_pkg.sv
// Shared constants, source numbering and FSM state type for the Z80 interrupt controller.
package z80bd_pkg;

    localparam logic [7:0] OFS_MASK  = 8'd0;
    localparam logic [7:0] OFS_PEND  = 8'd1;
    localparam logic [7:0] OFS_VBASE = 8'd2;
    localparam logic [7:0] OFS_SOFT  = 8'd3;

    localparam logic [1:0] SRC_UART  = 2'd0;
    localparam logic [1:0] SRC_TIMER = 2'd1;
    localparam logic [1:0] SRC_EXT   = 2'd2;
    localparam logic [1:0] SRC_SOFT  = 2'd3;

    localparam logic [4:0] VBASE_RST = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK,
        ST_DONE
    } int_state_t;

    // Lowest set index wins; an empty request maps to the spurious vector slot.
    function automatic logic [1:0] prio_src(input logic [3:0] req);
        logic [1:0] src;
        src = SRC_SOFT;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) src = 2'(i);
        end
        return src;
    endfunction

endpackage

// File: rtl/z80_sync_edge.sv
// Two-flop synchronizer with rise/fall pulses, one per asynchronous Z80-side input.
module z80_sync_edge #(
    parameter logic IDLE = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= IDLE;
            r_sync <= IDLE;
            r_prev <= IDLE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/z80_int_ctrl.sv
// Four-source vectored interrupt controller for a Z80 (mode 2 style vector on INTA).
// state | meaning: IDLE no request | REQ INT low | ACK vector latched | DONE wait for INTA end
module z80_int_ctrl
    import z80bd_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 480000,
    parameter logic [7:0]  PORT_BASE = 8'h18
) (
    input  logic       CLK_24MHz,
    input  logic       RES,
    input  logic       IORQ,
    input  logic       M1,
    input  logic       RD,
    input  logic       WR,
    input  logic [7:0] A,
    input  logic [7:0] D_in,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic       U_INT,
    input  logic       EXT_INT,
    output logic       INT
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    // bit order: IORQ, M1, RD, WR, U_INT, EXT_INT
    localparam logic [5:0] SYNC_IDLE = 6'b10_1111;

    logic [5:0] w_async;
    logic [5:0] w_sync;
    logic [5:0] w_rise;
    logic [5:0] w_fall;
    logic [9:0] w_unused;

    assign w_async = {EXT_INT, U_INT, WR, RD, M1, IORQ};

    for (genvar g = 0; g < 6; g++) begin : g_sync
        z80_sync_edge #(.IDLE(SYNC_IDLE[g])) u_sync (
            .i_clk   (CLK_24MHz),
            .i_rst_n (RES),
            .i_async (w_async[g]),
            .o_sync  (w_sync[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign w_unused = {w_rise, w_fall[4], w_fall[2:0]};

    logic       w_iorq_n, w_m1_n, w_rd_n, w_uint, w_wr_fall, w_ext_fall;
    logic [7:0] w_ofs;
    logic       w_hit, w_wr_strobe, w_rd_cond, w_inta;

    assign w_iorq_n    = w_sync[0];
    assign w_m1_n      = w_sync[1];
    assign w_rd_n      = w_sync[2];
    assign w_uint      = w_sync[4];
    assign w_wr_fall   = w_fall[3];
    assign w_ext_fall  = w_fall[5];
    assign w_ofs       = A - PORT_BASE;
    assign w_hit       = (w_ofs < 8'd4);
    assign w_wr_strobe = w_wr_fall & ~w_iorq_n & w_m1_n & w_hit;
    assign w_rd_cond   = ~w_iorq_n & ~w_rd_n & w_m1_n & w_hit;
    assign w_inta      = ~w_iorq_n & ~w_m1_n;

    logic [3:0]    r_mask;
    logic [3:1]    r_pend;
    logic [4:0]    r_vbase;
    logic [PW-1:0] r_presc;
    int_state_t    r_state, w_state_nxt;
    logic [1:0]    r_src, w_src_nxt;
    logic          r_int, r_rd_oe;
    logic [7:0]    r_rd_data, w_rd_mux;

    logic [3:0] w_pend, w_req;
    logic [3:1] w_set, w_clr;
    logic       w_tick, w_take, w_vec_phase;

    assign w_pend = {r_pend, w_uint};
    assign w_req  = w_pend & r_mask;
    assign w_tick = (r_presc == PRESC_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_inta) begin
                    w_state_nxt = ST_ACK;
                    w_src_nxt   = SRC_SOFT;
                end else if (|w_req) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_inta) begin
                    w_state_nxt = ST_ACK;
                    w_src_nxt   = prio_src(w_req);
                    w_take      = |w_req;
                end else if (~|w_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK:  w_state_nxt = ST_DONE;
            ST_DONE: if (w_m1_n && w_iorq_n) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Set events are OR-ed in after the clear so a simultaneous set survives.
    always_comb begin
        w_set            = '0;
        w_clr            = '0;
        w_set[SRC_TIMER] = w_tick;
        w_set[SRC_EXT]   = w_ext_fall;
        w_set[SRC_SOFT]  = w_wr_strobe && (w_ofs == OFS_SOFT) && D_in[0];
        if (w_wr_strobe && (w_ofs == OFS_PEND)) w_clr = D_in[3:1];
        if (w_take) begin
            case (w_src_nxt)
                SRC_UART:  ;
                SRC_TIMER: w_clr[SRC_TIMER] = 1'b1;
                SRC_EXT:   w_clr[SRC_EXT]   = 1'b1;
                SRC_SOFT:  w_clr[SRC_SOFT]  = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_ofs)
            OFS_MASK:  w_rd_mux = {4'h0, r_mask};
            OFS_PEND:  w_rd_mux = {4'h0, w_pend};
            OFS_VBASE: w_rd_mux = {r_vbase, 3'b000};
            default:   w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge CLK_24MHz) begin
        if (!RES) begin
            r_mask    <= '0;
            r_pend    <= '0;
            r_vbase   <= VBASE_RST;
            r_presc   <= '0;
            r_state   <= ST_IDLE;
            r_src     <= SRC_UART;
            r_int     <= 1'b1;
            r_rd_oe   <= 1'b0;
            r_rd_data <= 8'h00;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_wr_strobe && (w_ofs == OFS_MASK))  r_mask  <= D_in[3:0];
            if (w_wr_strobe && (w_ofs == OFS_VBASE)) r_vbase <= D_in[7:3];
            r_state   <= w_state_nxt;
            r_src     <= w_src_nxt;
            r_int     <= (w_state_nxt != ST_REQ);
            r_rd_oe   <= w_rd_cond;
            r_rd_data <= w_rd_cond ? w_rd_mux : 8'h00;
        end
    end

    assign w_vec_phase = (r_state == ST_ACK) || (r_state == ST_DONE);
    assign D_oe  = w_vec_phase | r_rd_oe;
    assign D_out = w_vec_phase ? {r_vbase, r_src, 1'b0} : r_rd_data;
    assign INT   = r_int;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Scoreboard bench: u_dut uses a slow tick for the bus tests, u_tick a 10-clock tick for timer tests.
module tb_z80_int_ctrl;

    localparam logic [7:0] PB = 8'h18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n, iorq_n, m1_n, rd_n, wr_n, u_int, ext_int;
    logic [7:0] a, d_in;
    logic [7:0] dout_a, dout_b;
    logic       doe_a, doe_b, int_a, int_b;

    z80_int_ctrl #(.TICK_DIV(50000), .PORT_BASE(PB)) u_dut (
        .CLK_24MHz(clk), .RES(res_n), .IORQ(iorq_n), .M1(m1_n), .RD(rd_n), .WR(wr_n),
        .A(a), .D_in(d_in), .D_out(dout_a), .D_oe(doe_a),
        .U_INT(u_int), .EXT_INT(ext_int), .INT(int_a)
    );

    z80_int_ctrl #(.TICK_DIV(10), .PORT_BASE(PB)) u_tick (
        .CLK_24MHz(clk), .RES(res_n), .IORQ(iorq_n), .M1(m1_n), .RD(rd_n), .WR(wr_n),
        .A(a), .D_in(d_in), .D_out(dout_b), .D_oe(doe_b),
        .U_INT(u_int), .EXT_INT(ext_int), .INT(int_b)
    );

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic       mon_a = 1'b0, mon_b = 1'b0;
    logic       prev_a = 1'b0, prev_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every rising D_oe is a presented byte, compared against the queue head.
    always @(negedge clk) begin
        if (mon_a && doe_a && !prev_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut_unexpected_oe: got D_out=0x%0h, expected no output", dout_a);
            end else begin
                chk("dut_dout", dout_a, q_a.pop_front());
            end
        end
        prev_a <= doe_a;
    end

    always @(negedge clk) begin
        if (mon_b && doe_b && !prev_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL tick_unexpected_oe: got D_out=0x%0h, expected no output", dout_b);
            end else begin
                chk("tick_dout", dout_b, q_b.pop_front());
            end
        end
        prev_b <= doe_b;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic io_write(input logic [7:0] ofs, input logic [7:0] data);
        a = PB + ofs; d_in = data; iorq_n = 1'b0;
        tick(3);
        wr_n = 1'b0;
        tick(4);
        wr_n = 1'b1; iorq_n = 1'b1;
        tick(3);
    endtask

    task automatic io_read(input logic [7:0] ofs, input logic [7:0] exp, input bit which);
        a = PB + ofs;
        if (which) q_b.push_back(exp); else q_a.push_back(exp);
        iorq_n = 1'b0; rd_n = 1'b0;
        tick(5);
        rd_n = 1'b1; iorq_n = 1'b1;
        tick(4);
    endtask

    task automatic wait_int(input bit which, input logic lvl, input int bound, input string name);
        int n = 0;
        while (((which ? int_b : int_a) !== lvl) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        chk(name, which ? int_b : int_a, lvl);
    endtask

    task automatic inta(input bit which, input logic [7:0] vec, input bit drop_uint);
        int n = 0;
        if (which) q_b.push_back(vec); else q_a.push_back(vec);
        m1_n = 1'b0; iorq_n = 1'b0;
        while (((which ? doe_b : doe_a) !== 1'b1) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        chk("inta_oe", which ? doe_b : doe_a, 1);
        tick(1);
        chk("int_high_after_ack", which ? int_b : int_a, 1);
        if (drop_uint) begin
            u_int = 1'b0;
            tick(4);
        end
        m1_n = 1'b1; iorq_n = 1'b1;
        tick(5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int t[7];
    int n;

    initial begin
        res_n = 1'b0; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        u_int = 1'b0; ext_int = 1'b1; a = 8'h00; d_in = 8'h00;
        tick(3);
        res_n = 1'b1;
        tick(2);

        // reset state
        chk("rst_int", int_a, 1);
        chk("rst_doe", doe_a, 0);
        chk("rst_dout", dout_a, 8'h00);
        mon_a = 1'b1;
        io_read(8'd0, 8'h00, 0);
        io_read(8'd2, 8'hF8, 0);

        // UART level: INT low exactly 3 clocks after U_INT rises, vector uses reset vbase
        io_write(8'd0, 8'h01);
        u_int = 1'b1;
        tick(2);
        chk("uart_int_2clk", int_a, 1);
        tick(1);
        chk("uart_int_3clk", int_a, 0);
        inta(0, 8'hF8, 1);
        tick(3);
        chk("int_after_uart_drop", int_a, 1);

        // EXT fall and SOFT write on the same clock, served by priority
        io_write(8'd2, 8'h40);
        io_read(8'd2, 8'h40, 0);
        io_write(8'd0, 8'h0F);
        a = PB + 8'd3; d_in = 8'h01; iorq_n = 1'b0;
        tick(3);
        wr_n = 1'b0; ext_int = 1'b0;
        tick(4);
        wr_n = 1'b1; iorq_n = 1'b1;
        tick(3);
        ext_int = 1'b1;
        io_read(8'd1, 8'h0C, 0);
        wait_int(0, 1'b0, 10, "t032_int1");
        inta(0, 8'h44, 0);
        wait_int(0, 1'b0, 10, "t032_int2");
        inta(0, 8'h46, 0);
        io_read(8'd1, 8'h00, 0);
        chk("t032_int_idle", int_a, 1);

        // timer on u_tick: period 10, vector vbase|2, INT high after ACK
        mon_a = 1'b0; mon_b = 1'b1;
        io_write(8'd0, 8'h02);
        io_write(8'd1, 8'h0E);
        for (int r = 0; r < 7; r++) begin
            wait_int(1, 1'b0, 40, "t033_int_low");
            t[r] = cyc;
            inta(1, 8'h42, 0);
        end
        chk("timer_period_a", t[5] - t[4], 10);
        chk("timer_period_b", t[6] - t[5], 10);

        // W1C of pending[1] on the tick clock: set wins
        wait_int(1, 1'b0, 40, "t035_int_low");
        a = PB + 8'd1; d_in = 8'h02; iorq_n = 1'b0;
        tick(6);
        wr_n = 1'b0;
        tick(4);
        chk("t035_int_held", int_b, 0);
        wr_n = 1'b1; iorq_n = 1'b1;
        tick(3);
        io_read(8'd1, 8'h02, 1);
        mon_b = 1'b0; mon_a = 1'b1;

        // mask cleared while in REQ: INT releases within 2 clocks, FSM back in IDLE
        io_write(8'd0, 8'h04);
        ext_int = 1'b0;
        tick(4);
        wait_int(0, 1'b0, 10, "t034_int_low");
        ext_int = 1'b1;
        a = PB; d_in = 8'h00; iorq_n = 1'b0;
        tick(3);
        wr_n = 1'b0;
        tick(2);
        chk("t034_int_before", int_a, 0);
        tick(2);
        chk("t034_int_after", int_a, 1);
        wr_n = 1'b1; iorq_n = 1'b1;
        tick(3);
        inta(0, 8'h46, 0);
        io_read(8'd1, 8'h04, 0);

        // reset during ACK
        io_write(8'd0, 8'h08);
        io_write(8'd3, 8'h01);
        wait_int(0, 1'b0, 10, "t036_int_low");
        q_a.push_back(8'h46);
        m1_n = 1'b0; iorq_n = 1'b0;
        n = 0;
        while ((doe_a !== 1'b1) && (n < 8)) begin
            @(negedge clk);
            n++;
        end
        chk("t036_ack_oe", doe_a, 1);
        res_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
        tick(1);
        chk("t036_doe", doe_a, 0);
        chk("t036_int", int_a, 1);
        chk("t036_dout", dout_a, 8'h00);
        tick(2);
        res_n = 1'b1;
        tick(3);
        io_read(8'd0, 8'h00, 0);
        io_read(8'd1, 8'h00, 0);
        io_read(8'd2, 8'hF8, 0);
        io_read(8'd3, 8'h00, 0);
        chk("t036_int_final", int_a, 1);

        tick(2);
        chk("q_dut_empty", q_a.size(), 0);
        chk("q_tick_empty", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
